// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin two-master arbiter for the shared single-port RAM
module mem_bus_arbiter #(
  parameter int ADR_W = 32
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             cpu_mem_op,
  input  logic [ADR_W-1:0] cpu_adr,
  input  logic [31:0]      cpu_do,
  input  logic [3:0]       cpu_wren,
  output logic [31:0]      cpu_di,
  output logic             cpu_ready,
  input  logic             dbg_mem_op,
  input  logic [ADR_W-1:0] dbg_adr,
  input  logic [31:0]      dbg_do,
  input  logic [3:0]       dbg_wren,
  output logic [31:0]      dbg_di,
  output logic             dbg_ready,
  output logic             mem_en,
  output logic [ADR_W-1:0] mem_adr,
  output logic [31:0]      mem_do,
  output logic [3:0]       mem_wren,
  input  logic [31:0]      mem_di,
  output logic             grant_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic MST_CPU = 1'b0;
  localparam logic MST_DBG = 1'b1;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             grant_dbg_q, grant_dbg_d;
  logic             mem_en_q, mem_en_d;
  logic [3:0]       mem_wren_q, mem_wren_d;
  logic [ADR_W-1:0] mem_adr_q, mem_adr_d;
  logic [31:0]      mem_do_q, mem_do_d;
  logic             pick_dbg;

  // State and RAM-port registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      last_q      <= MST_DBG;
      grant_dbg_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wren_q  <= 4'd0;
      mem_adr_q   <= '0;
      mem_do_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      grant_dbg_q <= grant_dbg_d;
      mem_en_q    <= mem_en_d;
      mem_wren_q  <= mem_wren_d;
      mem_adr_q   <= mem_adr_d;
      mem_do_q    <= mem_do_d;
    end
  end

  // Arbitration and transaction sequencing: IDLE picks a winner, ACCESS strobes the RAM, DONE returns data.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_dbg_d = grant_dbg_q;
    mem_en_d    = mem_en_q;
    mem_wren_d  = mem_wren_q;
    mem_adr_d   = mem_adr_q;
    mem_do_d    = mem_do_q;
    // Debug wins when it is the only requester, or on a tie when the CPU was served last.
    pick_dbg    = dbg_mem_op && (!cpu_mem_op || (last_q == MST_CPU));
    case (state_q)
      IDLE: begin
        if (cpu_mem_op || dbg_mem_op) begin
          state_d     = ACCESS;
          last_d      = pick_dbg;
          grant_dbg_d = pick_dbg;
          mem_en_d    = 1'b1;
          mem_adr_d   = pick_dbg ? dbg_adr  : cpu_adr;
          mem_do_d    = pick_dbg ? dbg_do   : cpu_do;
          mem_wren_d  = pick_dbg ? dbg_wren : cpu_wren;
        end
      end
      ACCESS: begin
        state_d    = DONE;
        mem_en_d   = 1'b0;
        mem_wren_d = 4'd0;
      end
      DONE: begin
        state_d     = IDLE;
        grant_dbg_d = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        grant_dbg_d = 1'b0;
        mem_en_d    = 1'b0;
        mem_wren_d  = 4'd0;
      end
    endcase
  end

  assign mem_en    = mem_en_q;
  assign mem_wren  = mem_wren_q;
  assign mem_adr   = mem_adr_q;
  assign mem_do    = mem_do_q;
  assign grant_dbg = grant_dbg_q;

  // Read data is passed straight through; it is only meaningful while the owner's ready is high.
  assign cpu_di    = mem_di;
  assign dbg_di    = mem_di;
  assign cpu_ready = (state_q == DONE) && !grant_dbg_q;
  assign dbg_ready = (state_q == DONE) &&  grant_dbg_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        cpu_mem_op, dbg_mem_op;
  logic [31:0] cpu_adr, cpu_do, dbg_adr, dbg_do;
  logic [3:0]  cpu_wren, dbg_wren;
  logic [31:0] cpu_di, dbg_di;
  logic        cpu_ready, dbg_ready;
  logic        mem_en, grant_dbg;
  logic [31:0] mem_adr, mem_do, mem_di;
  logic [3:0]  mem_wren;

  logic [31:0] ram [0:63];

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADR_W(32)) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .cpu_mem_op (cpu_mem_op),
    .cpu_adr    (cpu_adr),
    .cpu_do     (cpu_do),
    .cpu_wren   (cpu_wren),
    .cpu_di     (cpu_di),
    .cpu_ready  (cpu_ready),
    .dbg_mem_op (dbg_mem_op),
    .dbg_adr    (dbg_adr),
    .dbg_do     (dbg_do),
    .dbg_wren   (dbg_wren),
    .dbg_di     (dbg_di),
    .dbg_ready  (dbg_ready),
    .mem_en     (mem_en),
    .mem_adr    (mem_adr),
    .mem_do     (mem_do),
    .mem_wren   (mem_wren),
    .mem_di     (mem_di),
    .grant_dbg  (grant_dbg)
  );

  // Synchronous RAM: byte-enabled write, read data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wren[b]) ram[mem_adr[7:2]][8*b +: 8] <= mem_do[8*b +: 8];
      mem_di <= ram[mem_adr[7:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic xact(input logic is_dbg, input logic [31:0] adr, input logic [31:0] wdata,
                      input logic [3:0] wren, output logic [31:0] rdata, output int lat,
                      output int en_cyc, output logic [3:0] wren_seen, output logic grant_seen,
                      output int other_rdy);
    bit done;
    int i;
    rdata = '0; lat = 0; en_cyc = 0; wren_seen = '0; grant_seen = 1'b0; other_rdy = 0;
    done = 1'b0; i = 0;
    if (is_dbg) begin
      dbg_adr = adr; dbg_do = wdata; dbg_wren = wren; dbg_mem_op = 1'b1;
    end else begin
      cpu_adr = adr; cpu_do = wdata; cpu_wren = wren; cpu_mem_op = 1'b1;
    end
    while (!done && i < 12) begin
      @(negedge clk);
      i++;
      if (mem_en) begin
        en_cyc++;
        wren_seen  = mem_wren;
        grant_seen = grant_dbg;
      end
      if (is_dbg ? cpu_ready : dbg_ready) other_rdy++;
      if (is_dbg ? dbg_ready : cpu_ready) begin
        lat   = i;
        rdata = is_dbg ? dbg_di : cpu_di;
        done  = 1'b1;
      end
    end
    @(posedge clk); #1;
    if (is_dbg) dbg_mem_op = 1'b0;
    else        cpu_mem_op = 1'b0;
  endtask

  task automatic do_wr(input logic is_dbg, input logic [31:0] adr, input logic [31:0] data,
                       input logic [3:0] wren, input string tag);
    logic [31:0] rd; int lat, en_cyc, oth; logic [3:0] ws; logic gs;
    xact(is_dbg, adr, data, wren, rd, lat, en_cyc, ws, gs, oth);
    check({tag, "_lat"},   32'(lat), 32'd3);
    check({tag, "_en"},    32'(en_cyc), 32'd1);
    check({tag, "_wren"},  32'(ws), 32'(wren));
    check({tag, "_grant"}, 32'(gs), 32'(is_dbg));
    check({tag, "_other"}, 32'(oth), 32'd0);
  endtask

  task automatic do_rd(input logic is_dbg, input logic [31:0] adr, input logic [31:0] exp,
                       input string tag);
    logic [31:0] rd; int lat, en_cyc, oth; logic [3:0] ws; logic gs;
    xact(is_dbg, adr, 32'h0, 4'h0, rd, lat, en_cyc, ws, gs, oth);
    check({tag, "_lat"},   32'(lat), 32'd3);
    check({tag, "_en"},    32'(en_cyc), 32'd1);
    check({tag, "_data"},  rd, exp);
    check({tag, "_other"}, 32'(oth), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_en"},   32'(mem_en), 32'd0);
    check({tag, "_wren"}, 32'(mem_wren), 32'd0);
    check({tag, "_adr"},  mem_adr, 32'd0);
    check({tag, "_do"},   mem_do, 32'd0);
    check({tag, "_rdy"},  32'({cpu_ready, dbg_ready}), 32'd0);
    check({tag, "_gnt"},  32'(grant_dbg), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cpu_mem_op = 1'b0; cpu_adr = '0; cpu_do = '0; cpu_wren = '0;
    dbg_mem_op = 1'b0; dbg_adr = '0; dbg_do = '0; dbg_wren = '0;
    n_reset = 1'b1;
    #1 n_reset = 1'b0;
    #2 check_reset_outs("por");
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(posedge clk); #1;

    // Single reads and writes from each master.
    do_wr(1'b1, 32'h20, 32'h12345678, 4'hF, "pre20");
    do_rd(1'b0, 32'h20, 32'h12345678, "cpu_rd");
    check("adr_hold", mem_adr, 32'h20);
    check("en_idle", 32'(mem_en), 32'd0);
    do_wr(1'b1, 32'h20, 32'hAABBCCDD, 4'hF, "dbg_wr");
    do_rd(1'b0, 32'h20, 32'hAABBCCDD, "cpu_rd2");
    do_wr(1'b1, 32'h24, 32'h11223344, 4'hF, "pre24");
    do_wr(1'b0, 32'h24, 32'hFFFFFFFF, 4'b0010, "byte_wr");
    do_rd(1'b0, 32'h24, 32'h1122FF44, "byte_rd");

    // Tie straight after reset: CPU first, debug three cycles later.
    @(negedge clk) n_reset = 1'b0;
    @(negedge clk) n_reset = 1'b1;
    @(posedge clk); #1;
    cpu_adr = 32'h20; cpu_wren = 4'h0; cpu_mem_op = 1'b1;
    dbg_adr = 32'h24; dbg_wren = 4'h0; dbg_mem_op = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      check($sformatf("tie_c%0d", c), 32'({cpu_ready, dbg_ready, grant_dbg, mem_en}),
            32'({c == 3, c == 6, (c == 5) || (c == 6), (c == 2) || (c == 5)}));
      if (c == 3) check("tie_cpu_di", cpu_di, 32'hAABBCCDD);
      if (c == 6) check("tie_dbg_di", dbg_di, 32'h1122FF44);
      @(posedge clk); #1;
      if (c == 3) cpu_mem_op = 1'b0;
      if (c == 6) dbg_mem_op = 1'b0;
    end

    // CPU spinning on loads of 0x20 while debug issues two writes.
    do_wr(1'b1, 32'h20, 32'h0, 4'hF, "pre_spin");
    cpu_adr = 32'h20; cpu_wren = 4'h0; cpu_mem_op = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      logic exp_c, exp_d;
      exp_c = (c == 3) || (c == 6) || (c == 12) || (c == 18) || (c == 21);
      exp_d = (c == 9) || (c == 15);
      @(negedge clk);
      check($sformatf("spin_c%0d", c), 32'({cpu_ready, dbg_ready}), 32'({exp_c, exp_d}));
      if (exp_c) check($sformatf("spin_di_c%0d", c), cpu_di, (c < 9) ? 32'h0 : 32'hAABBCCDD);
      @(posedge clk); #1;
      if (c == 5) begin
        dbg_adr = 32'h20; dbg_do = 32'hAABBCCDD; dbg_wren = 4'hF; dbg_mem_op = 1'b1;
      end
      if (c == 9) begin
        dbg_adr = 32'h28; dbg_do = 32'h5A5A5A5A;
      end
      if (c == 15) dbg_mem_op = 1'b0;
      if (c == 21) cpu_mem_op = 1'b0;
    end
    do_rd(1'b0, 32'h28, 32'h5A5A5A5A, "dbg_wr2");

    // Reset asserted during the ACCESS cycle of a CPU read.
    cpu_adr = 32'h20; cpu_wren = 4'h0; cpu_mem_op = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_en", 32'(mem_en), 32'd1);
    #2 n_reset = 1'b0;
    #1 check_reset_outs("rst_mid");
    cpu_mem_op = 1'b0;
    dbg_adr = 32'h24; dbg_wren = 4'h0; dbg_mem_op = 1'b1;
    @(posedge clk); #1;
    check("rst_hold_rdy", 32'({cpu_ready, dbg_ready}), 32'd0);
    @(negedge clk) n_reset = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("rst_post_c%0d", c), 32'({cpu_ready, dbg_ready}), 32'({1'b0, c == 2}));
      if (c == 2) check("rst_post_di", dbg_di, 32'h1122FF44);
      @(posedge clk); #1;
      if (c == 2) dbg_mem_op = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
